// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: rebuilds hex digits from a scanned active-low 7-seg bus.
// Build macro SEG7_ALT_GLYPH_EN also accepts the alternate 7 and 9 glyphs.
module seg7_scan_decoder #(
  parameter int NDIG   = 4,
  parameter int STABLE = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        seg,
  input  logic [NDIG-1:0]   dig_en,
  input  logic              err_clr,
  output logic [4*NDIG-1:0] value,
  output logic [NDIG-1:0]   dig_valid,
  output logic              upd,
  output logic [2:0]        upd_idx,
  output logic              err
);

  localparam int CW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE);
  localparam logic [CW-1:0] CONE = CW'(1);
  localparam logic [6:0] BLANK = 7'b1111111;

  logic [6:0]        last_q [NDIG];
  logic [6:0]        last_d [NDIG];
  logic [CW-1:0]     cnt_q  [NDIG];
  logic [CW-1:0]     cnt_d  [NDIG];
  logic [4*NDIG-1:0] value_q, value_d;
  logic [NDIG-1:0]   dig_valid_q, dig_valid_d;
  logic              upd_q, upd_d;
  logic [2:0]        upd_idx_q, upd_idx_d;
  logic              err_q, err_d;

  // {decodable, blank, nibble}
  function automatic logic [5:0] decode(input logic [6:0] s);
    logic [5:0] r;
    r = 6'b000000;
    case (s)
      7'b1000000: r = 6'b10_0000;
      7'b1111001: r = 6'b10_0001;
      7'b0100100: r = 6'b10_0010;
      7'b0110000: r = 6'b10_0011;
      7'b0011001: r = 6'b10_0100;
      7'b0010010: r = 6'b10_0101;
      7'b0000010: r = 6'b10_0110;
      7'b1111000: r = 6'b10_0111;
      7'b0000000: r = 6'b10_1000;
      7'b0011000: r = 6'b10_1001;
      7'b0001000: r = 6'b10_1010;
      7'b0000011: r = 6'b10_1011;
      7'b1000110: r = 6'b10_1100;
      7'b0100001: r = 6'b10_1101;
      7'b0000110: r = 6'b10_1110;
      7'b0001110: r = 6'b10_1111;
`ifdef SEG7_ALT_GLYPH_EN
      7'b1011000: r = 6'b10_0111;
      7'b0010000: r = 6'b10_1001;
`endif
      BLANK:      r = 6'b01_0000;
      default:    r = 6'b00_0000;
    endcase
    return r;
  endfunction

  int            hits;
  logic          same;
  logic          commit;
  logic [CW-1:0] nxt;
  logic [5:0]    dec;

  // Stability filter and commit logic for the strobed slot
  always_comb begin
    value_d     = value_q;
    dig_valid_d = dig_valid_q;
    upd_d       = 1'b0;
    upd_idx_d   = upd_idx_q;
    err_d       = err_q & ~err_clr;
    same        = 1'b0;
    commit      = 1'b0;
    nxt         = '0;
    dec         = '0;
    for (int i = 0; i < NDIG; i++) begin
      last_d[i] = last_q[i];
      cnt_d[i]  = cnt_q[i];
    end
    hits = $countones(dig_en);
    if (hits > 1) err_d = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (hits == 1 && dig_en[i]) begin
        same = (seg == last_q[i]);
        if (same) begin
          nxt = (cnt_q[i] == CMAX) ? cnt_q[i] : cnt_q[i] + CONE;
        end else begin
          nxt       = CONE;
          last_d[i] = seg;
        end
        cnt_d[i] = nxt;
        // a changed glyph always restarts the run, even at STABLE=1
        commit = (nxt == CMAX) && (!same || cnt_q[i] != CMAX);
        if (commit) begin
          upd_d     = 1'b1;
          upd_idx_d = 3'(i);
          dec       = decode(seg);
          if (dec[5]) begin
            value_d[4*i +: 4] = dec[3:0];
            dig_valid_d[i]    = 1'b1;
          end else begin
            dig_valid_d[i] = 1'b0;
            if (!dec[4]) err_d = 1'b1;
          end
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NDIG; i++) begin
        last_q[i] <= BLANK;
        cnt_q[i]  <= '0;
      end
      value_q     <= '0;
      dig_valid_q <= '0;
      upd_q       <= 1'b0;
      upd_idx_q   <= 3'd0;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < NDIG; i++) begin
        last_q[i] <= last_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      value_q     <= value_d;
      dig_valid_q <= dig_valid_d;
      upd_q       <= upd_d;
      upd_idx_q   <= upd_idx_d;
      err_q       <= err_d;
    end
  end

  assign value     = value_q;
  assign dig_valid = dig_valid_q;
  assign upd       = upd_q;
  assign upd_idx   = upd_idx_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: random and directed checks against a run-length model.
// Honours SEG7_ALT_GLYPH_EN the same way as the design.
module tb_seg7_scan_decoder;

  localparam int NDIG = 4;
  localparam int STABLE = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = 7'h7f;
  logic [3:0]  dig_en = 4'b0;
  logic        err_clr = 1'b0;
  logic [15:0] value;
  logic [3:0]  dig_valid;
  logic        upd;
  logic [2:0]  upd_idx;
  logic        err;

  seg7_scan_decoder #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .dig_en(dig_en),
    .err_clr(err_clr), .value(value), .dig_valid(dig_valid),
    .upd(upd), .upd_idx(upd_idx), .err(err)
  );

  always #5 clk = ~clk;

  logic [6:0] glyphs [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int n_vec = 0;
  int n_bad = 0;
  int upd_seen = 0;

  logic [6:0]  m_last [4];
  int          m_run [4];
  logic [15:0] e_value;
  logic [3:0]  e_valid;
  logic        e_upd;
  logic [2:0]  e_idx;
  logic        e_err;

  // 0..15 digit, 16 blank, -1 undecodable
  function automatic int glyph(input logic [6:0] s);
    for (int k = 0; k < 16; k++) if (glyphs[k] == s) return k;
    if (s == 7'b1111111) return 16;
`ifdef SEG7_ALT_GLYPH_EN
    if (s == 7'b1011000) return 7;
    if (s == 7'b0010000) return 9;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_last[k] = 7'b1111111;
      m_run[k] = 0;
    end
    e_value = '0; e_valid = '0; e_upd = 0; e_idx = 0; e_err = 0;
  endtask

  // commit happens exactly when the run of identical samples reaches STABLE
  task automatic model_clock(input logic [3:0] en, input logic [6:0] s,
                             input logic clr);
    int g;
    e_upd = 0;
    if (clr) e_err = 0;
    if ($countones(en) > 1) e_err = 1;
    else for (int k = 0; k < 4; k++) if (en[k]) begin
      if (s == m_last[k]) m_run[k]++;
      else begin m_last[k] = s; m_run[k] = 1; end
      if (m_run[k] == STABLE) begin
        e_upd = 1; e_idx = 3'(k);
        g = glyph(s);
        if (g >= 0 && g < 16) begin
          e_value[4*k +: 4] = 4'(g); e_valid[k] = 1;
        end else begin
          e_valid[k] = 0;
          if (g < 0) e_err = 1;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("value", 32'(value), 32'(e_value));
    chk("dig_valid", 32'(dig_valid), 32'(e_valid));
    chk("upd", 32'(upd), 32'(e_upd));
    chk("upd_idx", 32'(upd_idx), 32'(e_idx));
    chk("err", 32'(err), 32'(e_err));
  endtask

  task automatic step(input logic [3:0] en, input logic [6:0] s,
                      input logic clr);
    dig_en = en; seg = s; err_clr = clr;
    @(posedge clk);
    model_clock(en, s, clr);
    #1;
    compare();
    if (upd) upd_seen++;
  endtask

  task automatic async_reset();
    dig_en = 0; err_clr = 0;
    #2 rst_n = 0;
    #1 model_reset();
    compare();
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    compare();
  endtask

  task automatic rr_scan(input int rounds, input logic [6:0] p0,
                         input logic [6:0] p1, input logic [6:0] p2,
                         input logic [6:0] p3, input logic chk_last);
    logic [6:0] p [4];
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    for (int r = 0; r < rounds; r++) begin
      if (r == rounds - 1) upd_seen = 0;
      for (int k = 0; k < 4; k++) begin
        step(4'(1 << k), p[k], 0);
        if (chk_last && r == rounds - 1) chk("rr_idx", 32'(upd_idx), k);
      end
    end
  endtask

  initial begin
    logic [6:0] cur [4];
    logic [6:0] pool [20];
    int r, a, b;
    model_reset();
    #3; compare();
    @(negedge clk) rst_n = 1;

    // hold digit 3 on slot 0
    upd_seen = 0;
    for (int c = 0; c < 3; c++) step(4'b0001, 7'b0110000, 0);
    chk("h3_upd", 32'(upd), 1);
    chk("h3_idx", 32'(upd_idx), 0);
    chk("h3_nib", 32'(value[3:0]), 3);
    chk("h3_valid", 32'(dig_valid), 4'b0001);
    upd_seen = 0;
    for (int c = 0; c < 10; c++) step(4'b0001, 7'b0110000, 0);
    chk("h3_hold", upd_seen, 0);

    rr_scan(3, 7'b1111001, 7'b0001000, 7'b0000011, 7'b0001110, 1);
    chk("rr_value", 32'(value), 32'hFBA1);
    chk("rr_valid", 32'(dig_valid), 4'hF);
    chk("rr_upds", upd_seen, 4);

    upd_seen = 0;
    for (int c = 0; c < 8; c++)
      step(4'b0100, c[0] ? 7'b0000000 : 7'b0000010, 0);
    chk("alt_upds", upd_seen, 0);
    chk("alt_value", 32'(value), 32'hFBA1);

    for (int c = 0; c < 3; c++) step(4'b0010, 7'b1010101, 0);
    chk("bad_valid1", 32'(dig_valid[1]), 0);
    chk("bad_err", 32'(err), 1);
    chk("bad_nib", 32'(value[7:4]), 4'hA);
    step(4'b0000, 7'b1010101, 1);
    chk("clr_err", 32'(err), 0);
    step(4'b0011, 7'b0000000, 0);
    chk("multi_err", 32'(err), 1);

    for (int c = 0; c < 3; c++) step(4'b0001, 7'b1011000, 0);
`ifdef SEG7_ALT_GLYPH_EN
    chk("alt7_nib", 32'(value[3:0]), 7);
    chk("alt7_valid", 32'(dig_valid[0]), 1);
`else
    chk("alt7_valid", 32'(dig_valid[0]), 0);
    chk("alt7_err", 32'(err), 1);
`endif

    rr_scan(3, 7'b1111001, 7'b0001000, 7'b0000011, 7'b0001110, 0);
    chk("pre_valid", 32'(dig_valid), 4'hF);
    step(4'b0001, 7'b1111001, 0);
    async_reset();
    chk("post_valid", 32'(dig_valid), 0);
    rr_scan(3, 7'b1111001, 7'b0001000, 7'b0000011, 7'b0001110, 1);
    chk("re_value", 32'(value), 32'hFBA1);
    chk("re_upds", upd_seen, 4);

    for (int k = 0; k < 16; k++) pool[k] = glyphs[k];
    pool[16] = 7'b1111111; pool[17] = 7'b1010101;
    pool[18] = 7'b1011000; pool[19] = 7'b0010000;
    for (int k = 0; k < 4; k++) cur[k] = pool[$urandom_range(0, 19)];
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0)
        cur[$urandom_range(0, 3)] = pool[$urandom_range(0, 19)];
      r = $urandom_range(0, 9);
      a = $urandom_range(0, 3);
      if (r == 0) begin
        step(4'b0000, cur[a], $urandom_range(0, 15) == 0);
      end else if (r == 1) begin
        b = (a + $urandom_range(1, 3)) % 4;
        step(4'((1 << a) | (1 << b)), cur[a], $urandom_range(0, 15) == 0);
      end else begin
        step(4'(1 << a), cur[a], $urandom_range(0, 15) == 0);
      end
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Recovers hexadecimal digit values from a multiplexed, active-low seven-segment display bus and presents them as a registered word. It sits on the board-level display path, sampling the same segment/digit-strobe lines that drive the on-board hex displays. It gives self-test logic and the debug readback port a loopback check of what the displays actually show. Each digit slot has a stability filter so that a glyph is committed only after it has been seen unchanged over several scan visits.

## Interface
- NDIG, 4: number of digit slots on the scanned bus (1..8).
- STABLE, 3: consecutive identical samples of a slot required before commit (>=1).
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- seg  input  7  segment lines, bit order {g,f,e,d,c,b,a}, active-low (0 = lit).
- dig_en  input  NDIG  digit strobes, active-high, expected one-hot; bit i selects slot i.
- err_clr  input  1  synchronous clear of err.
- value  output  4*NDIG  decoded nibbles; slot i at value[4i+3:4i].
- dig_valid  output  NDIG  slot i holds a valid committed glyph.
- upd  output  1  one-cycle pulse on every commit.
- upd_idx  output  3  slot index of the commit flagged by upd.
- err  output  1  sticky: undecodable glyph committed or multi-hot strobe seen.

## Operation
- Glyph set, seg value -> nibble: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. Blank = 1111111.
- Per-slot state: last[i] (7 bits) and cnt[i] (width $clog2(STABLE+1)).
- dig_en == 0: no state change.
- dig_en multi-hot: sample discarded, no slot state changes, err set.
- dig_en one-hot at slot i:
  - If seg == last[i]: cnt[i] <= min(cnt[i]+1, STABLE).
  - Otherwise: last[i] <= seg and cnt[i] <= 1.
- Commit occurs when the new cnt[i] equals STABLE and the old cnt[i] did not. A held pattern therefore commits exactly once; any change restarts counting.
- Commit outcomes:
  - Valid glyph: value slot i <= nibble, dig_valid[i] <= 1.
  - Blank: dig_valid[i] <= 0, nibble retained.
  - Any other pattern: dig_valid[i] <= 0, nibble retained, err <= 1.
- Every commit pulses upd = 1 for one cycle with upd_idx = i.
- err_clr clears err. If a set condition occurs in the same cycle, set wins.

## Timing
- Reset values:
  - value = 0, dig_valid = 0, upd = 0, upd_idx = 0, err = 0.
  - All last[i] = 1111111, all cnt[i] = 0.
- Assertion of rst_n mid-scan clears all state immediately, without waiting for clk.
- Commit latency: outputs change on the same clk edge that captures the STABLE-th identical sample. They are visible in the following cycle, and upd is high for exactly that one cycle.
- With STABLE = 1, every slot sample whose pattern differs from last[i] commits, and so does the first sample after reset.
- Slots are independent. Samples of other slots, or idle cycles, between visits to slot i do not reset cnt[i].
- upd_idx holds its last value while upd = 0.

## Configuration
- SEG7_ALT_GLYPH_EN defined:
  - 1011000 additionally decodes to 7 (7 with segment f lit).
  - 0010000 additionally decodes to 9 (9 with segment d lit).
  - Both alternates are valid glyphs.
- SEG7_ALT_GLYPH_EN undefined: both alternates are undecodable and set err on commit.

## Test plan
- Reset with NDIG=4, STABLE=3, then hold dig_en=0001, seg=0110000 for 3 cycles:
  - upd pulses once with upd_idx=0.
  - value[3:0]=3, dig_valid=0001, err=0.
  - Holding the pattern 10 more cycles produces no further upd.
- Round-robin scan of slots 0..3 showing 1,A,b,F (each visit 1 cycle, 3 full rounds) -> value=16'hFbA1, dig_valid=1111, four upd pulses with idx 0,1,2,3 in the third round.
- Slot 2 alternates between 0000010 and 0000000 on every visit -> no commit, value unchanged, upd never asserts.
- Commit 1010101 on slot 1 -> dig_valid[1]=0, err=1, old nibble retained. Then pulse err_clr -> err=0. Then dig_en=0011 for 1 cycle -> err=1, no slot state change.
- Commit 1011000 on slot 0 -> value[3:0]=7, dig_valid[0]=1 with SEG7_ALT_GLYPH_EN defined; without it, dig_valid[0]=0 and err=1.
- After valid digits on all slots, drop rst_n mid-scan -> value=0, dig_valid=0, err=0 immediately. Re-running the scan after release recommits after 3 visits per slot.
